// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and constants.
// Build option: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
package imem_loader_pkg;

  localparam int WORD_W         = 17;
  localparam int BYTES_PER_WORD = 3;
  localparam int B0_HI_BIT      = 0;
  localparam int INSTR_HI_BIT   = 16;

  typedef enum logic [2:0] {
    S_CNT_HI,
    S_CNT_LO,
    S_B2,
    S_B1,
    S_B0,
    S_RUN,
    S_ERR,
    S_CSUM
  } state_t;

endpackage

// File: rtl/imem_ram.sv
// Instruction word store: synchronous write, asynchronous read.
// No reset; contents survive reloads.
module imem_ram #(
  parameter int WORD_W = 17,
  parameter int DEPTH  = 128,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Byte-serial program loader and instruction server for PMIPSL0.
// Build option: IMEM_LOADER_CHECKSUM_EN (trailing XOR byte check).
module imem_loader #(
  parameter int WORD_W = imem_loader_pkg::WORD_W,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  input  logic              reload,
  input  logic [ADDR_W-1:0] imemaddr,
  output logic [WORD_W-1:0] imemrdata,
  output logic              cpu_reset,
  output logic              ld_err,
  output logic [7:0]        words_loaded
);

  import imem_loader_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_LAST = S_CSUM;
  logic [7:0] csum;
`else
  localparam state_t S_LAST = S_RUN;
`endif

  state_t            state, state_n;
  logic [15:0]       count;
  logic              hi_bit;
  logic [7:0]        mid;
  logic              xfer, last, we;
  logic [WORD_W-1:0] wdata, rdata;
  logic              hit;

  assign xfer  = ld_valid & ld_ready;
  assign last  = ({8'd0, words_loaded} + 16'd1) == count;
  assign we    = xfer & ~reload & (state == S_B0);
  assign wdata = {hi_bit, mid, ld_byte};

  always_comb begin
    state_n = state;
    if (reload) begin
      state_n = S_CNT_HI;
    end else if (xfer) begin
      unique case (state)
        S_CNT_HI: state_n = S_CNT_LO;
        S_CNT_LO: begin
          if ({count[15:8], ld_byte} > DEPTH16)
            state_n = S_ERR;
          else if ({count[15:8], ld_byte} == 16'd0)
            state_n = S_LAST;
          else
            state_n = S_B2;
        end
        S_B2: state_n = S_B1;
        S_B1: state_n = S_B0;
        S_B0: state_n = last ? S_LAST : S_B2;
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: state_n = (csum == ld_byte) ? S_RUN : S_ERR;
`endif
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_CNT_HI;
      cpu_reset    <= 1'b1;
      ld_ready     <= 1'b1;
      ld_err       <= 1'b0;
      words_loaded <= 8'd0;
      count        <= 16'd0;
      hi_bit       <= 1'b0;
      mid          <= 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= 8'd0;
`endif
    end else begin
      state     <= state_n;
      cpu_reset <= (state_n != S_RUN);
      ld_ready  <= (state_n != S_RUN) && (state_n != S_ERR);
      ld_err    <= (state_n == S_ERR);
      if (reload) begin
        words_loaded <= 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum         <= 8'd0;
`endif
      end else if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= csum ^ ld_byte;
`endif
        unique case (state)
          S_CNT_HI: count[15:8]  <= ld_byte;
          S_CNT_LO: count[7:0]   <= ld_byte;
          S_B2:     hi_bit       <= ld_byte[B0_HI_BIT];
          S_B1:     mid          <= ld_byte;
          S_B0:     words_loaded <= words_loaded + 8'd1;
          default: ;
        endcase
      end
    end
  end

  imem_ram #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (words_loaded[AW-1:0]),
    .wdata (wdata),
    .raddr (imemaddr[AW:1]),
    .rdata (rdata)
  );

  // Reads past the loaded image return zero, never stale words.
  assign hit = (state == S_RUN) &&
               (32'(imemaddr[ADDR_W-1:1]) < 32'(count));
  assign imemrdata = hit ? rdata : '0;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader.
// Honors IMEM_LOADER_CHECKSUM_EN when defined for the build.
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];

  logic        clock = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_ready;
  logic        reload;
  logic [15:0] imemaddr;
  logic [16:0] imemrdata;
  logic        cpu_reset;
  logic        ld_err;
  logic [7:0]  words_loaded;

  int checks = 0;
  int errors = 0;

  bq_t         img;
  logic [16:0] wv[$];
  logic [16:0] exp_mem [128];
  int          exp_cnt;
  bit          exp_run, exp_err;
  int          exp_wl;

  always #5 clock = ~clock;

  imem_loader dut (
    .clock        (clock),
    .reset        (reset),
    .ld_valid     (ld_valid),
    .ld_byte      (ld_byte),
    .ld_ready     (ld_ready),
    .reload       (reload),
    .imemaddr     (imemaddr),
    .imemrdata    (imemrdata),
    .cpu_reset    (cpu_reset),
    .ld_err       (ld_err),
    .words_loaded (words_loaded)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Image = 16-bit BE count, 3 bytes per word, optional XOR trailer.
  task automatic build_img(input int n, input bit rnd_hi,
                           input bit bad_csum);
    logic [7:0] x;
    logic [6:0] junk;
    img.delete();
    img.push_back(8'(n >> 8));
    img.push_back(8'(n));
    if (n <= 128) begin
      foreach (wv[i]) begin
        junk = rnd_hi ? 7'($urandom) : 7'd0;
        img.push_back({junk, wv[i][16]});
        img.push_back(wv[i][15:8]);
        img.push_back(wv[i][7:0]);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      x = 8'd0;
      foreach (img[i]) x = x ^ img[i];
      img.push_back(bad_csum ? ~x : x);
`else
      x = 8'(bad_csum);
`endif
    end
  endtask

  task automatic model_load(input int n, input bit bad_csum);
    exp_cnt = n;
    exp_run = 1'b0;
    exp_err = 1'b0;
    exp_wl  = 0;
    if (n > 128) begin
      exp_err = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) exp_mem[i] = wv[i];
      exp_wl = n;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (bad_csum) exp_err = 1'b1;
      else exp_run = 1'b1;
`else
      exp_run = !bad_csum;
`endif
    end
  endtask

  function automatic logic [16:0] exp_rd(input logic [15:0] a);
    int idx;
    idx = int'(a >> 1);
    if (exp_run && idx < exp_cnt) return exp_mem[idx];
    return 17'd0;
  endfunction

  task automatic send(input int gap, input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clock);
      if (i > 0) chk("rst_hold", cpu_reset, 1);
      ld_valid = 1'b1;
      ld_byte  = img[i];
      for (int g = 0; g < gap; g++) begin
        @(negedge clock);
        ld_valid = 1'b0;
        ld_byte  = 8'($urandom);
        if (i < lim - 1) chk("gap_hold", cpu_reset, 1);
      end
    end
    @(negedge clock);
    ld_valid = 1'b0;
  endtask

  task automatic check_state();
    chk("cpu_reset", cpu_reset, !exp_run);
    chk("ld_err", ld_err, exp_err);
    chk("ld_ready", ld_ready, !(exp_run || exp_err));
    chk("words", words_loaded, exp_wl);
  endtask

  task automatic check_reads(input int n);
    int lim;
    lim = (n > 128) ? 4 : n + 2;
    for (int k = 0; k < lim; k++) begin
      imemaddr = 16'(2 * k) | 16'($urandom_range(0, 1));
      #1 chk("rd", imemrdata, exp_rd(imemaddr));
    end
    repeat (4) begin
      imemaddr = 16'($urandom);
      #1 chk("rd_rnd", imemrdata, exp_rd(imemaddr));
    end
  endtask

  task automatic pulse_reload();
    @(negedge clock);
    reload   = 1'b1;
    ld_valid = 1'b1;
    ld_byte  = 8'hFF;
    @(negedge clock);
    reload   = 1'b0;
    ld_valid = 1'b0;
    exp_run  = 1'b0;
    exp_err  = 1'b0;
    exp_wl   = 0;
    imemaddr = 16'd0;
    #1;
    check_state();
    chk("rl_rd", imemrdata, 0);
  endtask

  task automatic run_load(input int n, input int gap, input bit rnd_hi,
                          input bit bad);
    build_img(n, rnd_hi, bad);
    send(gap, img.size());
    model_load(n, bad);
    check_state();
    check_reads(n);
  endtask

  initial begin
    int n;
    reset    = 1'b0;
    ld_valid = 1'b0;
    ld_byte  = 8'd0;
    reload   = 1'b0;
    imemaddr = 16'd0;
    exp_run  = 1'b0;
    exp_err  = 1'b0;
    exp_wl   = 0;
    exp_cnt  = 0;
    repeat (2) @(negedge clock);
    check_state();
    chk("rst_rd", imemrdata, 0);
    reset = 1'b1;
    @(negedge clock);
    check_state();

    wv = '{17'h0C283, 17'h0F701};
    run_load(2, 0, 1'b0, 1'b0);
    imemaddr = 16'd0; #1 chk("dir_w0", imemrdata, 17'h0C283);
    imemaddr = 16'd2; #1 chk("dir_w1", imemrdata, 17'h0F701);
    imemaddr = 16'd4; #1 chk("dir_w2", imemrdata, 0);

    pulse_reload();
    run_load(2, 3, 1'b0, 1'b0);
    imemaddr = 16'd2; #1 chk("gap_w1", imemrdata, 17'h0F701);

    pulse_reload();
    wv.delete();
    run_load(200, 0, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clock);
      ld_valid = 1'b1;
      ld_byte  = 8'($urandom);
    end
    @(negedge clock);
    ld_valid = 1'b0;
    check_state();
    pulse_reload();

    run_load(129, 1, 1'b0, 1'b0);
    pulse_reload();

    wv = '{17'h10000};
    run_load(1, 0, 1'b0, 1'b0);
    imemaddr = 16'd0; #1 chk("dir_hi", imemrdata, 17'h10000);

    // Partial load interrupted by reload; coincident byte must drop.
    pulse_reload();
    wv.delete();
    for (int i = 0; i < 5; i++) wv.push_back(17'($urandom));
    build_img(5, 1'b1, 1'b0);
    send(0, 7);
    chk("part_wl", words_loaded, 1);
    chk("part_rst", cpu_reset, 1);
    pulse_reload();

    wv.delete();
    run_load(0, 0, 1'b0, 1'b0);
    pulse_reload();

    for (int t = 0; t < 8; t++) begin
      n = (t == 0) ? 128 : $urandom_range(1, 24);
      wv.delete();
      for (int i = 0; i < n; i++) wv.push_back(17'($urandom));
      run_load(n, $urandom_range(0, 2), 1'b1, 1'b0);
      pulse_reload();
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    wv = '{17'h01234};
    run_load(1, 0, 1'b0, 1'b1);
    pulse_reload();
    run_load(1, 0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
